// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_elastic_stage #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 24,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              acc;
    logic              emt;

    // With the skid buffer in_ready is a flop; without it, it looks through to out_ready.
    assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid | out_ready);
    assign acc      = in_valid & in_ready;
    assign emt      = out_valid & out_ready;
    assign out_data = main_data_q;
    assign out_ctrl = main_ctrl_q;

    // State register and payload storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            out_valid   <= 1'b0;
            in_ready_q  <= 1'b1;
            stall_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            out_valid   <= out_valid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt   <= stall_cnt_d;
        end
    end

    // Next-state, payload movement and counter update
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d     = FULL;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            FULL: begin
                if (acc && emt) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (emt) begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                end else if (acc && (SKID != 0)) begin
                    state_d     = SKID_FULL;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end
            end
            SKID_FULL: begin
                if (emt) begin
                    state_d     = FULL;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_ctrl_d = '0;
                end
            end
            default: begin
                state_d     = EMPTY;
                main_ctrl_d = '0;
                skid_ctrl_d = '0;
            end
        endcase

        // Flush discards everything, including a same-cycle accept; data is kept.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = '0;
            skid_data_d = skid_data_q;
            skid_ctrl_d = '0;
        end

        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != SKID_FULL);

        stall_cnt_d = stall_cnt;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt_d = stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed bench for pipe_elastic_stage: skid, no-skid and 4-bit-counter
// instances share one stimulus set; each scenario checks the relevant instance.
module tb_pipe_elastic_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          cnt_clr;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [CW-1:0] a_out_ctrl;
    logic [15:0]   a_stall;
    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [CW-1:0] b_out_ctrl;
    logic [15:0]   b_stall;
    logic          c_in_ready, c_out_valid;
    logic [DW-1:0] c_out_data;
    logic [CW-1:0] c_out_ctrl;
    logic [3:0]    c_stall;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl), .stall_cnt(a_stall), .cnt_clr(cnt_clr));

    pipe_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl), .stall_cnt(b_stall), .cnt_clr(cnt_clr));

    pipe_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .out_ctrl(c_out_ctrl), .stall_cnt(c_stall), .cnt_clr(cnt_clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_a got %b want 1", a_in_ready); end
        n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_b got %b want 1", b_in_ready); end
        do_reset();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", a_out_valid); end
        n_cmp++; if (a_out_ctrl !== 8'h00) begin n_bad++; $display("FAIL rst_out_ctrl got %h want 00", a_out_ctrl); end
        n_cmp++; if (a_out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data got %h want 0", a_out_data); end
        n_cmp++; if (a_stall !== 16'd0) begin n_bad++; $display("FAIL rst_stall got %0d want 0", a_stall); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_post_in_ready got %b want 1", a_in_ready); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(CW'(i), 32'h100 + DW'(i));
            tick();
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_ctrl !== CW'(i)) begin n_bad++; $display("FAIL stream_a[%0d] got v=%b c=%h want v=1 c=%h", i, a_out_valid, a_out_ctrl, CW'(i)); end
            n_cmp++; if (a_out_data !== 32'h100 + DW'(i) || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_a_data[%0d] got d=%h r=%b want d=%h r=1", i, a_out_data, a_in_ready, 32'h100 + DW'(i)); end
            n_cmp++; if (b_out_valid !== 1'b1 || b_out_ctrl !== CW'(i)) begin n_bad++; $display("FAIL stream_b[%0d] got v=%b c=%h want v=1 c=%h", i, b_out_valid, b_out_ctrl, CW'(i)); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00) begin n_bad++; $display("FAIL stream_drain got v=%b c=%h want v=0 c=00", a_out_valid, a_out_ctrl); end
        n_cmp++; if (a_out_data !== 32'h108) begin n_bad++; $display("FAIL stream_data_hold got %h want 108", a_out_data); end
        n_cmp++; if (a_stall !== 16'd0 || b_stall !== 16'd0) begin n_bad++; $display("FAIL stream_stall got a=%0d b=%0d want 0", a_stall, b_stall); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        send(8'hA1, 32'hAAAA);
        tick();
        out_ready = 1'b0;
        send(8'hB2, 32'hBBBB);
        #1;
        n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_before_b got %b want 1", a_in_ready); end
        tick();
        n_cmp++; if (a_in_ready !== 1'b0 || a_out_ctrl !== 8'hA1) begin n_bad++; $display("FAIL bp_skid_full got r=%b c=%h want r=0 c=a1", a_in_ready, a_out_ctrl); end
        send(8'hC3, 32'hCCCC);
        tick();
        tick();
        n_cmp++; if (a_out_ctrl !== 8'hA1 || a_in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold got c=%h r=%b want c=a1 r=0", a_out_ctrl, a_in_ready); end
        n_cmp++; if (a_stall !== 16'd3) begin n_bad++; $display("FAIL bp_stall got %0d want 3", a_stall); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (a_out_ctrl !== 8'hB2 || a_out_data !== 32'hBBBB || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_out_b got c=%h d=%h r=%b want c=b2 d=bbbb r=1", a_out_ctrl, a_out_data, a_in_ready); end
        tick();
        n_cmp++; if (a_out_ctrl !== 8'hC3 || a_out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_c got c=%h v=%b want c=c3 v=1", a_out_ctrl, a_out_valid); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (a_out_valid !== 1'b0 || a_stall !== 16'd3) begin n_bad++; $display("FAIL bp_drain got v=%b s=%0d want v=0 s=3", a_out_valid, a_stall); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        send(8'h11, 32'h1111);
        tick();
        out_ready = 1'b0;
        send(8'h22, 32'h2222);
        tick();
        send(8'h33, 32'h3333);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00) begin n_bad++; $display("FAIL flush_empty got v=%b c=%h want v=0 c=00", a_out_valid, a_out_ctrl); end
        n_cmp++; if (a_in_ready !== 1'b1 || a_stall !== 16'd1) begin n_bad++; $display("FAIL flush_ready_cnt got r=%b s=%0d want r=1 s=1", a_in_ready, a_stall); end
        n_cmp++; if (a_out_data !== 32'h1111) begin n_bad++; $display("FAIL flush_data_hold got %h want 1111", a_out_data); end
        tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_ghost got v=%b want 0", a_out_valid); end
        send(8'h44, 32'h4444);
        tick();
        n_cmp++; if (a_out_ctrl !== 8'h44 || a_out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_resume got c=%h v=%b want c=44 v=1", a_out_ctrl, a_out_valid); end
        send(8'h55, 32'h5555);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00) begin n_bad++; $display("FAIL flush_over_acc got v=%b c=%h want v=0 c=00", a_out_valid, a_out_ctrl); end
        tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_acc_dropped got v=%b want 0", a_out_valid); end
    endtask

    task automatic test_noskid();
        do_reset();
        out_ready = 1'b1;
        send(8'h61, 32'h6161);
        tick();
        send(8'h62, 32'h6262);
        out_ready = 1'b0;
        #1;
        n_cmp++; if (b_in_ready !== 1'b0) begin n_bad++; $display("FAIL ns_ready_low got %b want 0", b_in_ready); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL ns_ready_follow got %b want 1", b_in_ready); end
        out_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (b_out_ctrl !== 8'h61 || b_out_data !== 32'h6161 || b_out_valid !== 1'b1) begin n_bad++; $display("FAIL ns_hold got c=%h d=%h v=%b want c=61 d=6161 v=1", b_out_ctrl, b_out_data, b_out_valid); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (b_out_ctrl !== 8'h62) begin n_bad++; $display("FAIL ns_next got c=%h want 62", b_out_ctrl); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (b_out_valid !== 1'b0 || b_stall !== 16'd2) begin n_bad++; $display("FAIL ns_drain got v=%b s=%0d want v=0 s=2", b_out_valid, b_stall); end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b1;
        send(8'h71, 32'h7171);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (20) tick();
        n_cmp++; if (c_stall !== 4'd15 || c_out_valid !== 1'b1) begin n_bad++; $display("FAIL sat_cnt got s=%0d v=%b want s=15 v=1", c_stall, c_out_valid); end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        n_cmp++; if (c_stall !== 4'd0) begin n_bad++; $display("FAIL sat_clr got %0d want 0", c_stall); end
        tick();
        n_cmp++; if (c_stall !== 4'd1) begin n_bad++; $display("FAIL sat_recount got %0d want 1", c_stall); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        send(8'h81, 32'h8181);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (a_stall !== 16'd2 || a_out_ctrl !== 8'h81) begin n_bad++; $display("FAIL ar_pre got s=%0d c=%h want s=2 c=81", a_stall, a_out_ctrl); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_out_data !== 32'h0) begin n_bad++; $display("FAIL ar_outputs got v=%b c=%h d=%h want 0", a_out_valid, a_out_ctrl, a_out_data); end
        n_cmp++; if (a_stall !== 16'd0 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL ar_cnt_ready got s=%0d r=%b want s=0 r=1", a_stall, a_in_ready); end
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'h82, 32'h8282);
        tick();
        n_cmp++; if (a_out_ctrl !== 8'h82 || a_out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_resume got c=%h v=%b want c=82 v=1", a_out_ctrl, a_out_valid); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_drain got v=%b want 0", a_out_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_noskid();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
